// File: rtl/raised_symbol_sampler.sv
// Symbol decimator, sign slicer, sync hunter and MSB-first byte packer fed by raised_receiver.
// Optional squelch abort is compiled in with `define RAISED_SAMPLER_SQUELCH_EN.
module raised_symbol_sampler #(
  parameter int unsigned SPS           = 8,
  parameter int unsigned SAMPLE_PHASE  = 4,
  parameter logic [7:0]  SYNC_WORD     = 8'hA5,
  parameter int unsigned FRAME_BYTES   = 4,
  parameter logic [15:0] SQUELCH_LEVEL = 16'd512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] datain,
  input  logic        readready,
  input  logic        waitwrite,
  output logic [7:0]  dataout,
  output logic        writeready,
  output logic        locked,
  output logic        frame_done,
  output logic        overrun,
  output logic        frame_abort
);

  localparam int unsigned PW = $clog2(SPS);
  localparam int unsigned BW = $clog2(FRAME_BYTES + 1);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic          last_held;

  logic       dec;
  logic       xfer;
  logic       accept;
  logic       last_byte;
  logic       byte_done;
  logic       abort;
  logic [7:0] sh_next;

  assign dec       = readready && (phase == PW'(SAMPLE_PHASE));
  assign sh_next   = {shreg[6:0], ~datain[15]};
  assign xfer      = writeready && waitwrite;
  assign accept    = !writeready || xfer;
  assign last_byte = (byte_cnt == BW'(FRAME_BYTES - 1));
  assign byte_done = (state == LOCK) && dec && (bit_cnt == 3'd7) && !abort;

  // Final byte either leaves with its transfer, or, if dropped, flags on its completion cycle.
  assign frame_done = (xfer && last_held) || (byte_done && last_byte && !accept);

`ifdef RAISED_SAMPLER_SQUELCH_EN
  logic [15:0] mag;
  logic [1:0]  low_cnt;
  logic        low;

  always_comb begin
    mag = datain;
    if (datain[15]) mag = (datain == 16'h8000) ? 16'h7FFF : (~datain + 16'd1);
  end

  assign low   = (mag < SQUELCH_LEVEL);
  assign abort = (state == LOCK) && dec && low && (low_cnt == 2'd3);
`else
  logic unused_bits;
  assign unused_bits = &{1'b0, datain[14:0]};
  assign abort       = 1'b0;
  assign frame_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      phase      <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      last_held  <= 1'b0;
      dataout    <= '0;
      writeready <= 1'b0;
      locked     <= 1'b0;
      overrun    <= 1'b0;
`ifdef RAISED_SAMPLER_SQUELCH_EN
      low_cnt     <= '0;
      frame_abort <= 1'b0;
`endif
    end else begin
      if (readready) phase <= (phase == PW'(SPS - 1)) ? '0 : phase + 1'b1;

      if (xfer) begin
        writeready <= 1'b0;
        last_held  <= 1'b0;
      end

      // A same-cycle transfer frees the holding register, so the new byte loads instead of dropping.
      if (byte_done) begin
        if (accept) begin
          dataout    <= sh_next;
          writeready <= 1'b1;
          last_held  <= last_byte;
        end else begin
          overrun <= 1'b1;
        end
      end

`ifdef RAISED_SAMPLER_SQUELCH_EN
      frame_abort <= 1'b0;
`endif

      case (state)
        HUNT: begin
          if (dec) begin
            shreg <= sh_next;
            if (sh_next == SYNC_WORD) begin
              state    <= LOCK;
              locked   <= 1'b1;
              bit_cnt  <= '0;
              byte_cnt <= '0;
`ifdef RAISED_SAMPLER_SQUELCH_EN
              low_cnt  <= '0;
`endif
            end
          end
        end
        LOCK: begin
          if (abort) begin
            state   <= HUNT;
            locked  <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef RAISED_SAMPLER_SQUELCH_EN
            low_cnt     <= '0;
            frame_abort <= 1'b1;
`endif
          end else if (dec) begin
            shreg   <= sh_next;
            bit_cnt <= bit_cnt + 3'd1;
`ifdef RAISED_SAMPLER_SQUELCH_EN
            low_cnt <= low ? low_cnt + 2'd1 : 2'd0;
`endif
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + 1'b1;
              if (last_byte) begin
                state  <= HUNT;
                locked <= 1'b0;
                shreg  <= '0;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_raised_symbol_sampler.sv
// Directed bench for raised_symbol_sampler: table of byte vectors plus hand sequences for corner cases.
module tb_raised_symbol_sampler;

  localparam logic [15:0] POS  = 16'h03E8;  // +1000
  localparam logic [15:0] NEG  = 16'hFC18;  // -1000
  localparam logic [15:0] ZERO = 16'h0000;
  localparam logic [15:0] WEAK = 16'h0064;  // +100

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] datain;
  logic        readready;
  logic        waitwrite;
  logic [7:0]  dataout;
  logic        writeready;
  logic        locked;
  logic        frame_done;
  logic        overrun;
  logic        frame_abort;

  raised_symbol_sampler #(
    .SPS(8), .SAMPLE_PHASE(4), .SYNC_WORD(8'hA5), .FRAME_BYTES(4), .SQUELCH_LEVEL(16'd512)
  ) dut (
    .clk(clk), .reset(reset), .datain(datain), .readready(readready), .waitwrite(waitwrite),
    .dataout(dataout), .writeready(writeready), .locked(locked), .frame_done(frame_done),
    .overrun(overrun), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ww;
    logic [7:0]  tx;
    logic [15:0] one;
    logic        exp_wr;
    logic [7:0]  exp_do;
    logic        exp_lk;
    logic        exp_fd;
    logic        exp_ov;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int fa_cnt = 0;
  int wr_seen = 0;
  int lk_seen = 0;
  logic [7:0] got[$];

  logic       snap_wr, snap_lk, snap_fd, snap_ov, snap_fa;
  logic [7:0] snap_do;

  always @(negedge clk) begin
    if (writeready && waitwrite) got.push_back(dataout);
    if (frame_done)  fd_cnt++;
    if (frame_abort) fa_cnt++;
    if (writeready)  wr_seen++;
    if (locked)      lk_seen++;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] v);
    datain    = v;
    readready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    readready = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One symbol of 8 samples; only sample 4 carries the bit, the rest sit at -1000.
  task automatic send_sym(input logic b, input logic [15:0] one);
    for (int s = 0; s < 8; s++) begin
      drive((s == 4) ? (b ? one : NEG) : NEG);
      if (s == 4) begin
        snap_wr = writeready;
        snap_do = dataout;
        snap_lk = locked;
        snap_fd = frame_done;
        snap_ov = overrun;
        snap_fa = frame_abort;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [15:0] one);
    for (int i = 7; i >= 0; i--) send_sym(b[i], one);
  endtask

  vec_t       vecs[15];
  logic [7:0] exp_got[11];
  int         fd0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, POS,  1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h3C, POS,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hC3, POS,  1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, POS,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hFF, POS,  1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'hA5, POS,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h3C, POS,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'hC3, POS,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h00, POS,  1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 8'hFF, POS,  1'b1, 8'hFF, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 8'hA5, POS,  1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 8'h5A, ZERO, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 8'hC3, ZERO, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 8'h00, POS,  1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 8'h81, POS,  1'b1, 8'h81, 1'b0, 1'b1, 1'b1};
    exp_got  = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h3C, 8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h00, 8'h81};

    // Reset held with live random input.
    reset     = 1'b0;
    waitwrite = 1'b1;
    readready = 1'b1;
    datain    = '0;
    repeat (4) drive(16'($urandom));
    check("rst dataout",     16'(dataout),     16'h0000);
    check("rst writeready",  16'(writeready),  16'h0000);
    check("rst locked",      16'(locked),      16'h0000);
    check("rst frame_done",  16'(frame_done),  16'h0000);
    check("rst overrun",     16'(overrun),     16'h0000);
    check("rst frame_abort", 16'(frame_abort), 16'h0000);

    reset   = 1'b1;
    wr_seen = 0;
    repeat (64) drive(ZERO);
    check("post-reset idle writeready", 16'(wr_seen), 16'h0000);
    got.delete();
    fd_cnt = 0;

    // Basic, backpressure and zero-sample frames.
    for (int i = 0; i < 15; i++) begin
      waitwrite = vecs[i].ww;
      send_byte(vecs[i].tx, vecs[i].one);
      check($sformatf("v%0d writeready", i), 16'(snap_wr), 16'(vecs[i].exp_wr));
      check($sformatf("v%0d dataout", i),    16'(snap_do), 16'(vecs[i].exp_do));
      check($sformatf("v%0d locked", i),     16'(snap_lk), 16'(vecs[i].exp_lk));
      check($sformatf("v%0d frame_done", i), 16'(snap_fd), 16'(vecs[i].exp_fd));
      check($sformatf("v%0d overrun", i),    16'(snap_ov), 16'(vecs[i].exp_ov));
    end
    idle(2);
    check("table byte count", 16'(got.size()), 16'(11));
    for (int i = 0; i < 11; i++)
      if (i < got.size()) check($sformatf("table byte %0d", i), 16'(got[i]), 16'(exp_got[i]));
    check("table frame_done count", 16'(fd_cnt), 16'(3));

    // Final byte of a frame dropped: frame_done on its completion cycle, held byte delivered later.
    waitwrite = 1'b0;
    got.delete();
    fd0 = fd_cnt;
    send_byte(8'hA5, POS);
    send_byte(8'h11, POS);
    send_byte(8'h22, POS);
    send_byte(8'h33, POS);
    send_byte(8'h44, POS);
    check("dropfinal frame_done", 16'(fd_cnt - fd0), 16'(1));
    check("dropfinal locked",     16'(snap_lk), 16'h0000);
    check("dropfinal writeready", 16'(snap_wr), 16'h0001);
    check("dropfinal dataout",    16'(snap_do), 16'h0011);
    waitwrite = 1'b1;
    idle(2);
    check("dropfinal delivered count", 16'(got.size()), 16'(1));
    if (got.size() > 0) check("dropfinal delivered byte", 16'(got[0]), 16'h0011);
    check("dropfinal no extra frame_done", 16'(fd_cnt - fd0), 16'(1));
    check("dropfinal writeready low",      16'(writeready), 16'h0000);

    // False sync rejection.
    wr_seen = 0;
    lk_seen = 0;
    repeat (10) send_byte(8'hA4, POS);
    check("falsesync locked",     16'(lk_seen), 16'h0000);
    check("falsesync writeready", 16'(wr_seen), 16'h0000);

    // Low-energy decisions after sync.
    fd0    = fd_cnt;
    fa_cnt = 0;
    send_byte(8'hA5, POS);
    check("squelch sync locked", 16'(snap_lk), 16'h0001);
`ifdef RAISED_SAMPLER_SQUELCH_EN
    repeat (4) send_sym(1'b1, WEAK);
    check("squelch frame_abort",  16'(snap_fa), 16'h0001);
    check("squelch locked",       16'(snap_lk), 16'h0000);
    idle(2);
    check("squelch abort count",  16'(fa_cnt), 16'(1));
    check("squelch no frame_done", 16'(fd_cnt - fd0), 16'(0));
    check("squelch no byte",      16'(writeready), 16'h0000);
`else
    send_byte(8'hFF, WEAK);
    check("weak writeready",  16'(snap_wr), 16'h0001);
    check("weak dataout",     16'(snap_do), 16'h00FF);
    check("weak frame_abort", 16'(snap_fa), 16'h0000);
    repeat (3) send_byte(8'h00, POS);
    idle(2);
    check("weak locked end",   16'(snap_lk), 16'h0000);
    check("weak frame_done",   16'(fd_cnt - fd0), 16'(1));
    check("weak abort count",  16'(fa_cnt), 16'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/raised_symbol_sampler.md
Name: raised_symbol_sampler

Overview:
- Sits directly downstream of raised_receiver and consumes its 16-bit matched-filter output samples.
- Decimates the sample stream to one decision per symbol and slices each decision on its sign.
- Hunts for a sync byte, then packs the following bits MSB-first into bytes for the host-side consumer.
- Uses the same readready/writeready/waitwrite handshake as the filter chain.

Parameters:
- SPS, 8, samples per symbol; must be ≥2.
- SAMPLE_PHASE, 4, sample index within a symbol (0..SPS-1) at which the decision is taken.
- SYNC_WORD, 8'hA5, byte that must appear in the sliced bit stream to declare lock.
- FRAME_BYTES, 4, payload bytes delivered per lock before returning to hunt.
- SQUELCH_LEVEL, 16'd512, magnitude threshold used only by the optional feature.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- datain, input, 16, signed two's-complement sample from raised_receiver.
- readready, input, 1, datain valid this cycle; the block always accepts it, there is no backpressure upstream.
- waitwrite, input, 1, downstream ready; a byte transfers on a cycle where writeready && waitwrite.
- dataout, output, 8, payload byte.
- writeready, output, 1, dataout valid.
- locked, output, 1, high while in LOCK.
- frame_done, output, 1, one-cycle pulse when the last byte of a frame transfers.
- overrun, output, 1, sticky; set when a completed byte is dropped.
- frame_abort, output, 1, one-cycle pulse on squelch abort (optional feature only).

Behaviour:
Reset:
- All outputs go to 0 while reset = 0: dataout = 8'h00, writeready = 0, locked = 0, frame_done = 0, overrun = 0, frame_abort = 0.
- Phase counter = 0, shift register = 8'h00, bit count = 0, byte count = 0, state = HUNT.
- Reset asserted mid-frame discards any partial byte and any held byte.

Phase counter:
- Increments on each cycle with readready = 1 and wraps from SPS-1 to 0.
- It is free-running and is not realigned on lock.

Decision:
- Taken on a readready cycle where the counter equals SAMPLE_PHASE.
- bit = ~datain[15], so zero and positive samples give 1 and negative samples give 0.
- The bit shifts into the LSB of an 8-bit shift register.

HUNT state:
- The shift register is compared after each decision.
- On a match with SYNC_WORD, the next state is LOCK: locked = 1 from the next cycle, bit count = 0, byte count = 0.
- The register contents are then ignored until 8 new bits have arrived.

LOCK state:
- On each decision, bit count increments.
- When the 8th bit lands, the assembled byte (first received bit = MSB) is the completed byte.
  - If writeready = 0, or the held byte transfers in this same cycle: load dataout and set writeready = 1 on the next edge. Latency is one clock from the 8th decision sample.
  - Otherwise: drop the new byte and set overrun = 1 (cleared only by reset).
- Byte count increments on every completed byte, including dropped ones.
- writeready stays high and dataout stays stable until a cycle with waitwrite = 1; writeready falls on the following edge unless a new byte loads in the same cycle.
- Frame end: once the byte count reaches FRAME_BYTES, the block returns to HUNT with locked = 0 and the shift register cleared to 8'h00.
  - frame_done pulses in the cycle the final byte transfers. If the final byte was dropped, frame_done pulses on the completion cycle instead.
- A pending held byte still waits for waitwrite after the return to HUNT. Hunting continues in parallel.

Simultaneous events:
- A transfer and a new load in the same cycle are legal and produce no overrun.
- A readready with no decision only advances the counter.

Optional Feature:
- Macro RAISED_SAMPLER_SQUELCH_EN.
- When defined:
  - In LOCK, a decision with |datain| < SQUELCH_LEVEL increments a 2-bit low-energy counter; any decision at or above the level clears it. |-32768| saturates to 32767.
  - A 4th consecutive low decision aborts: return to HUNT, discard the partial byte, pulse frame_abort for one cycle, and do not pulse frame_done. A held byte is still delivered.
- When undefined: no magnitude check, and frame_abort is tied to 0.

Test Plan:
- Reset check: hold reset = 0 with random datain and readready = 1 → all outputs 0. Release reset → no writeready for 64 cycles of zero samples.
- Basic frame: SPS = 8. Drive ±1000 samples encoding A5, then 3C, C3, 00, FF, with waitwrite = 1 → locked rises after the 8th sync decision. Bytes 3C, C3, 00, FF appear, each 1 clock after its 8th decision. frame_done pulses on FF, then locked = 0.
- Backpressure: same frame with waitwrite = 0 until byte 2 completes → dataout holds 3C. Byte C3 is dropped and overrun = 1. Release waitwrite → 3C transfers, then 00 and FF.
- False sync rejection: stream 8'hA4 repeated 10 times → locked stays 0 and writeready stays 0.
- Sample phase/zero: sample value 0 at the decision point → bit 1. Non-decision samples at −1000 do not affect bits.
- Squelch (macro defined): after sync, 4 decisions at |datain| = 100 → frame_abort pulses, locked = 0, frame_done = 0. Without the macro, the same stimulus decodes bytes 8'hFF.
